// File: rtl/counter_ctrl_unit.sv
// counter_ctrl_unit: push-button front end for the 0-9999 counter.
// Sync, debounce and edge-detect three buttons; run/stop/clear FSM.
module counter_ctrl_unit #(
    parameter int SAMPLE_DIV = 100_000,
    parameter int DB_DEPTH   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_run_stop,
    input  logic       btn_clear,
    input  logic       btn_mode,
    output logic       enable,
    output logic       clear,
    output logic       mode,
    output logic [1:0] state_led
);

    localparam int DIV_W = $clog2(SAMPLE_DIV);
    localparam int NBTN  = 3;
    localparam int B_RUN = 0;
    localparam int B_CLR = 1;
    localparam int B_MOD = 2;

    typedef enum logic [1:0] {
        ST_STOP = 2'b00,
        ST_RUN  = 2'b01,
        ST_CLR  = 2'b10,
        ST_BAD  = 2'b11
    } state_t;

    logic [DIV_W-1:0]    div_cnt;
    logic                tick;
    logic [NBTN-1:0]     btn_raw;
    logic [NBTN-1:0]     sync1;
    logic [NBTN-1:0]     sync2;
    logic [DB_DEPTH-1:0] shreg [NBTN];
    logic [NBTN-1:0]     db;
    logic [NBTN-1:0]     db_d1;
    logic [NBTN-1:0]     press;
    state_t              state;
    logic                mode_q;

    assign btn_raw = {btn_mode, btn_clear, btn_run_stop};
    assign tick    = (div_cnt == DIV_W'(SAMPLE_DIV - 1));
    assign press   = db & ~db_d1;

    // Free-running sample divider, wraps at SAMPLE_DIV-1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Two-flop synchronizer for the asynchronous buttons
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    // Shift one synchronized sample per tick into each history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NBTN; i++) begin
                shreg[i] <= '0;
            end
        end else if (tick) begin
            for (int i = 0; i < NBTN; i++) begin
                shreg[i] <= {shreg[i][DB_DEPTH-2:0], sync2[i]};
            end
        end
    end

    // Debounced level changes only on a full run of equal samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db    <= '0;
            db_d1 <= '0;
        end else begin
            db_d1 <= db;
            for (int i = 0; i < NBTN; i++) begin
                if (&shreg[i]) begin
                    db[i] <= 1'b1;
                end else if (~|shreg[i]) begin
                    db[i] <= 1'b0;
                end
            end
        end
    end

    // Run/stop/clear FSM; run wins over clear, CLR lasts one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_STOP;
        end else begin
            unique case (state)
                ST_STOP: begin
                    if (press[B_RUN]) begin
                        state <= ST_RUN;
                    end else if (press[B_CLR]) begin
                        state <= ST_CLR;
                    end
                end
                ST_RUN: begin
                    if (press[B_RUN]) begin
                        state <= ST_STOP;
                    end
                end
                ST_CLR:  state <= ST_STOP;
                default: state <= ST_STOP;
            endcase
        end
    end

    // Mode toggles on every mode press regardless of state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= 1'b0;
        end else if (press[B_MOD]) begin
            mode_q <= ~mode_q;
        end
    end

    assign enable    = (state == ST_RUN);
    assign clear     = (state == ST_CLR);
    assign mode      = mode_q;
    assign state_led = state;

endmodule
